// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants, the per-axis phase type and the
// count-to-phase decoder used by both axis counters.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_PIPE_DELAY = 1;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } vga_phase_t;

    // Segments are laid out in order ACTIVE, FRONT, SYNC, BACK from count 0.
    function automatic vga_phase_t vga_phase_of(
        input logic [9:0] count,
        input int         visible_len,
        input int         front_len,
        input int         sync_len,
        input int         back_len
    );
        int pos;
        pos = int'(count);
        if (pos < visible_len)
            return ACTIVE;
        if (pos < visible_len + front_len)
            return FRONT;
        if (pos < visible_len + front_len + sync_len)
            return SYNC;
        if (pos < visible_len + front_len + sync_len + back_len)
            return BACK;
        return ACTIVE;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates, display enable, syncs and start strobes.
interface vga_timing_gen_if;

    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       hs_d;
    logic       vs_d;
    logic       frame_start;
    logic       line_start;

    modport master (
        output DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, line_start
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, hs_d, vs_d, frame_start, line_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping 10-bit counter that advances when enabled and
// reports its wrap and the phase its next count will fall in.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE_LEN = DEF_H_VISIBLE,
    parameter int FRONT_LEN   = DEF_H_FRONT,
    parameter int SYNC_LEN    = DEF_H_SYNC,
    parameter int BACK_LEN    = DEF_H_BACK
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap,
    output vga_phase_t phase_next
);

    localparam int         TOTAL = VISIBLE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
    localparam logic [9:0] LAST  = 10'(TOTAL - 1);

    generate
        if (TOTAL - 1 > 1023 || TOTAL < 1) begin : g_bad_total
            $error("vga_axis_counter: TOTAL-1 (%0d) does not fit in 10 bits", TOTAL - 1);
        end
    endgenerate

    logic [9:0] count_reg;
    logic [9:0] count_next;

    always_comb begin
        wrap       = en && (count_reg == LAST);
        count_next = count_reg;
        if (en)
            count_next = wrap ? 10'd0 : count_reg + 10'd1;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)
            count_reg <= 10'd0;
        else
            count_reg <= count_next;
    end

    assign count      = count_reg;
    assign phase_next = vga_phase_of(count_next, VISIBLE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing generator: coordinates plus registered blank,
// syncs and start strobes, and a sync delay line matching the RGB pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master bus
);

    generate
        if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY (%0d) must be 0..4", PIPE_DELAY);
        end
    endgenerate

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       h_wrap;
    logic       v_wrap;
    vga_phase_t h_phase_next;
    vga_phase_t v_phase_next;

    vga_axis_counter #(
        .VISIBLE_LEN (H_VISIBLE),
        .FRONT_LEN   (H_FRONT),
        .SYNC_LEN    (H_SYNC),
        .BACK_LEN    (H_BACK)
    ) u_h_counter (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .en         (1'b1),
        .count      (h_count),
        .wrap       (h_wrap),
        .phase_next (h_phase_next)
    );

    vga_axis_counter #(
        .VISIBLE_LEN (V_VISIBLE),
        .FRONT_LEN   (V_FRONT),
        .SYNC_LEN    (V_SYNC),
        .BACK_LEN    (V_BACK)
    ) u_v_counter (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (v_count),
        .wrap       (v_wrap),
        .phase_next (v_phase_next)
    );

    logic blank_reg;
    logic hs_reg;
    logic vs_reg;
    logic frame_start_reg;
    logic line_start_reg;

    // Registered from next-count values so each flag lands with its coordinates.
    // The next count is (0,*) exactly on an H wrap and (0,0) exactly on a V wrap.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blank_reg       <= 1'b0;
            hs_reg          <= 1'b1;
            vs_reg          <= 1'b1;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
        end else begin
            blank_reg       <= (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
            hs_reg          <= (h_phase_next != SYNC);
            vs_reg          <= (v_phase_next != SYNC);
            frame_start_reg <= v_wrap;
            line_start_reg  <= h_wrap;
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign bus.hs_d = hs_reg;
            assign bus.vs_d = vs_reg;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] hs_pipe_reg;
            logic [PIPE_DELAY-1:0] vs_pipe_reg;
            logic [PIPE_DELAY-1:0] hs_pipe_next;
            logic [PIPE_DELAY-1:0] vs_pipe_next;

            assign hs_pipe_next[0] = hs_reg;
            assign vs_pipe_next[0] = vs_reg;
            for (genvar gi = 1; gi < PIPE_DELAY; gi++) begin : g_stage
                assign hs_pipe_next[gi] = hs_pipe_reg[gi-1];
                assign vs_pipe_next[gi] = vs_pipe_reg[gi-1];
            end

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe_reg <= '1;
                    vs_pipe_reg <= '1;
                end else begin
                    hs_pipe_reg <= hs_pipe_next;
                    vs_pipe_reg <= vs_pipe_next;
                end
            end

            assign bus.hs_d = hs_pipe_reg[PIPE_DELAY-1];
            assign bus.vs_d = vs_pipe_reg[PIPE_DELAY-1];
        end
    endgenerate

    assign bus.DrawX       = h_count;
    assign bus.DrawY       = v_count;
    assign bus.blank       = blank_reg;
    assign bus.hs          = hs_reg;
    assign bus.vs          = vs_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.line_start  = line_start_reg;

endmodule
